// File: rtl/video_pkg.sv
// Default SVGA 800x600@60 timing constants, lock state type and a saturating
// counter helper shared by the video output stage.
package video_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic {
    SEEK   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/video_timing.sv
// Raster position counters and region decode for one video mode.
module video_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic active_o,
  output logic hsync_o,
  output logic vsync_o,
  output logic at_origin_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign active_o    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_o     = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
  assign vsync_o     = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
  assign at_origin_o = (hcnt_q == '0) && (vcnt_q == '0);

endmodule

// File: rtl/hdmi_video_out.sv
// HDMI output stage: aligns an SOF-tagged pixel stream to the raster, blanks
// on underflow or misalignment and relocks at the next frame origin.
module hdmi_video_out
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  input  logic        in_sof,
  output logic [23:0] hdmi_rgb,
  output logic        hdmi_hsync,
  output logic        hdmi_vsync,
  output logic        hdmi_videovalid,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] underflow_cnt
);

  logic active, hsync, vsync, at_origin;

  video_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .active_o    (active),
    .hsync_o     (hsync),
    .vsync_o     (vsync),
    .at_origin_o (at_origin)
  );

  lock_state_e state_q, state_d;
  logic        show, fail;
  logic        sof_misplaced;
  logic [23:0] rgb_q;
  logic        hsync_q, vsync_q, de_q, fs_q;
  logic [15:0] ucnt_q, ucnt_d;

  // An SOF anywhere but the origin is held back rather than consumed
  assign sof_misplaced = in_valid && in_sof && !at_origin;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= SEEK;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SEEK:    if (at_origin && in_valid && in_sof) state_d = LOCKED;
      LOCKED:  if (active && (!in_valid || sof_misplaced)) state_d = SEEK;
      default: state_d = SEEK;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    show     = 1'b0;
    fail     = 1'b0;
    case (state_q)
      SEEK: begin
        in_ready = !in_sof || at_origin;
        show     = at_origin && in_valid && in_sof;
      end
      LOCKED: begin
        in_ready = active && !sof_misplaced;
        fail     = active && (!in_valid || sof_misplaced);
        show     = active && in_valid && !sof_misplaced;
      end
      default: ;
    endcase
  end

  assign ucnt_d = fail ? sat_inc16(ucnt_q) : ucnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rgb_q   <= '0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      rgb_q   <= show ? in_rgb : 24'h0;
      hsync_q <= hsync;
      vsync_q <= vsync;
      de_q    <= active;
      fs_q    <= at_origin;
      ucnt_q  <= ucnt_d;
    end
  end

  assign hdmi_rgb        = rgb_q;
  assign hdmi_hsync      = hsync_q;
  assign hdmi_vsync      = vsync_q;
  assign hdmi_videovalid = de_q;
  assign frame_start     = fs_q;
  assign locked          = (state_q == LOCKED);
  assign underflow_cnt   = ucnt_q;

endmodule
